// File: rtl/rr_code_arbiter.sv
// rr_code_arbiter: round-robin arbiter that feeds a binary grant code to a
// downstream decoder over a valid/ready handshake.
// Optional feature macro: RR_CODE_ARBITER_GRANT_CNT_EN enables the saturating
// 16-bit accepted-grant counter. When it is not defined, grant_cnt reads as zero.
module rr_code_arbiter #(
    parameter int NUM_CODE_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [(1<<NUM_CODE_BITS)-1:0] req,
    output logic                     code_valid,
    output logic [NUM_CODE_BITS-1:0] code,
    input  logic                     code_ready,
    output logic [15:0]              grant_cnt
);

    localparam int NUM_REQ = 1 << NUM_CODE_BITS;
    localparam logic [NUM_CODE_BITS-1:0] CODE_ONE = NUM_CODE_BITS'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t                   state;
    logic [NUM_CODE_BITS-1:0] ptr;
    logic [NUM_CODE_BITS-1:0] arb_base;
    logic [NUM_CODE_BITS-1:0] pick;
    logic [NUM_CODE_BITS-1:0] idx;
    logic                     accept;
    logic                     any_req;

    assign accept  = (state == OFFER) && code_ready;
    assign any_req = |req;

    // Pick the first set request at or after the priority base, wrapping;
    // on an accept the base is already the advanced pointer (code+1).
    always_comb begin
        arb_base = accept ? (code + CODE_ONE) : ptr;
        pick     = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = arb_base + NUM_CODE_BITS'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    // Handshake FSM: capture a winner, hold it until accepted, then re-arbitrate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            code_valid <= 1'b0;
            code       <= '0;
            ptr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        code       <= pick;
                        code_valid <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (code_ready) begin
                        ptr <= code + CODE_ONE;
                        if (any_req) begin
                            code <= pick;
                        end else begin
                            code_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    code_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RR_CODE_ARBITER_GRANT_CNT_EN
    logic [15:0] cnt_q;

    // Count accepted grants, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rr_code_arbiter.sv
// tb_rr_code_arbiter: directed plus randomized checks of rr_code_arbiter
// against a behavioural round-robin model held in the bench.
module tb_rr_code_arbiter;

    localparam int NCB     = 3;
    localparam int NUM_REQ = 1 << NCB;

    logic               clk;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic               code_valid;
    logic [NCB-1:0]     code;
    logic               code_ready;
    logic [15:0]        grant_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, search by modular arithmetic.
    int m_ptr;
    int m_code;
    bit m_valid;
    int m_cnt;

    rr_code_arbiter #(.NUM_CODE_BITS(NCB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .grant_cnt  (grant_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int arbitrate(input logic [NUM_REQ-1:0] r, input int base);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(base + k) % NUM_REQ]) return (base + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_code  = 0;
        m_valid = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_step(input logic [NUM_REQ-1:0] r, input logic rdy);
        if (!m_valid) begin
            if (r != 0) begin
                m_code  = arbitrate(r, m_ptr);
                m_valid = 1;
            end
        end else if (rdy) begin
            m_ptr = (m_code + 1) % NUM_REQ;
`ifdef RR_CODE_ARBITER_GRANT_CNT_EN
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
            if (r != 0) m_code = arbitrate(r, m_ptr);
            else        m_valid = 0;
        end
    endfunction

    task automatic checkOutput(input string tag);
        logic [NCB-1:0] exp_code;
        logic [15:0]    exp_cnt;
        exp_code = m_code[NCB-1:0];
        exp_cnt  = m_cnt[15:0];
        checks++;
        assert (code_valid === m_valid) else begin
            errors++;
            $error("[TB] FAIL %s code_valid got %b want %b", tag, code_valid, m_valid);
        end
        checks++;
        assert (code === exp_code) else begin
            errors++;
            $error("[TB] FAIL %s code got %0d want %0d", tag, code, exp_code);
        end
        checks++;
        assert (grant_cnt === exp_cnt) else begin
            errors++;
            $error("[TB] FAIL %s grant_cnt got %0d want %0d", tag, grant_cnt, exp_cnt);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        assert (actual === expected) else begin
            errors++;
            $error("[TB] FAIL %s got %0d want %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic rdy, input string tag);
        req        = r;
        code_ready = rdy;
        @(posedge clk);
        model_step(r, rdy);
        #1;
        checkOutput(tag);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        req   = '0;
        code_ready = 1'b0;
        model_reset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NUM_REQ-1:0] r;
        logic               rdy;
        int                 exp_acc;

        rst_n = 1'b0;
        req = '0;
        code_ready = 1'b0;
        model_reset();

        // 1: single request
        applyReset();
        applyStimulus(8'b0000_0100, 1'b1, "single_load");
        checkValue("single_code", 32'(code), 32'd2);
        checkValue("single_valid", 32'(code_valid), 32'd1);
        applyStimulus(8'h00, 1'b1, "single_drop");
        checkValue("single_idle", 32'(code_valid), 32'd0);
        // ptr is now 3: with 0x09 requesting, 3 beats 0
        applyStimulus(8'h09, 1'b0, "single_ptr");
        checkValue("single_ptr_code", 32'(code), 32'd3);

        // 2: full load, codes 0..7,0 back to back
        applyReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'hFF, 1'b1, "full_load");
            checkValue("full_seq", 32'(code), 32'(i % NUM_REQ));
        end
`ifdef RR_CODE_ARBITER_GRANT_CNT_EN
        checkValue("cnt_after_full", 32'(grant_cnt), 32'd8);
`else
        checkValue("cnt_after_full", 32'(grant_cnt), 32'd0);
`endif

        // 3: backpressure
        applyReset();
        applyStimulus(8'h81, 1'b0, "bp_load");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h81, 1'b0, "bp_hold");
            checkValue("bp_code", 32'(code), 32'd0);
        end
        applyStimulus(8'h81, 1'b1, "bp_acc1");
        checkValue("bp_next7", 32'(code), 32'd7);
        // 4a: accepting 7 wraps ptr to 0, so 0 wins next
        applyStimulus(8'h81, 1'b1, "wrap_acc");
        checkValue("wrap_code0", 32'(code), 32'd0);

        // 4b: non-retraction
        applyReset();
        applyStimulus(8'h20, 1'b0, "nr_load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b0, "nr_hold");
            checkValue("nr_code5", 32'(code), 32'd5);
        end
        applyStimulus(8'h00, 1'b1, "nr_accept");
        checkValue("nr_code_kept", 32'(code), 32'd5);

        // 5: asynchronous reset between edges during an offer
        applyReset();
        applyStimulus(8'h40, 1'b0, "ar_load");
        checkValue("ar_code6", 32'(code), 32'd6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("ar_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h90, 1'b0, "ar_restart");
        checkValue("ar_code4", 32'(code), 32'd4);

        // 6: grant counter over 10 accepts
        applyReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(8'hFF, 1'b1, "cnt_run");
        end
`ifdef RR_CODE_ARBITER_GRANT_CNT_EN
        checkValue("cnt_ten", 32'(grant_cnt), 32'd10);
`else
        checkValue("cnt_ten", 32'(grant_cnt), 32'd0);
`endif

        // Random traffic against the model, with fairness bookkeeping
        applyReset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = NUM_REQ'(1 << $urandom_range(0, NUM_REQ - 1));
                2:       r = NUM_REQ'($urandom);
                default: r = NUM_REQ'($urandom & $urandom);
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(r, rdy, "random");
            if (i == 200) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                checkOutput("random_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Fairness: requester 5 held with all others busy is granted within NUM_REQ accepts
        applyReset();
        exp_acc = 0;
        applyStimulus(8'hFF, 1'b0, "fair_load");
        while (code !== 3'd5 && exp_acc < NUM_REQ + 2) begin
            applyStimulus(8'hFF, 1'b1, "fair_run");
            exp_acc++;
        end
        checkValue("fair_bound", 32'(exp_acc <= NUM_REQ), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
